// File: rtl/gelato_l2_arbiter.sv
// Round-robin merge of all SM inst/data request channels onto one registered L2 port, per-channel outstanding caps.
// Request path has 1-cycle latency; response routing is combinational; a full, stalled slot blocks every req_ready.
module gelato_l2_arbiter #(
  parameter int NUM_SM  = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4,
  localparam int NUM_CH = 2 * NUM_SM,
  localparam int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           rdy,
  input  logic [NUM_CH-1:0]              req_valid,
  output logic [NUM_CH-1:0]              req_ready,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_CH-1:0]              req_we,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  req_wdata,
  output logic                           l2_req_valid,
  input  logic                           l2_req_ready,
  output logic [ADDR_W-1:0]              l2_req_addr,
  output logic                           l2_req_we,
  output logic [DATA_W-1:0]              l2_req_wdata,
  output logic [ID_W-1:0]                l2_req_id,
  input  logic                           l2_rsp_valid,
  output logic                           l2_rsp_ready,
  input  logic [ID_W-1:0]                l2_rsp_id,
  input  logic [DATA_W-1:0]              l2_rsp_data,
  output logic [NUM_CH-1:0]              rsp_valid,
  output logic [DATA_W-1:0]              rsp_data,
  output logic                           proto_err
);

  localparam int CNT_W = 4;

  logic                         r_slot_vld;
  logic [ADDR_W-1:0]            r_addr;
  logic                         r_we;
  logic [DATA_W-1:0]            r_wdata;
  logic [ID_W-1:0]              r_id;
  logic [ID_W-1:0]              r_rr_ptr;
  logic [NUM_CH-1:0][CNT_W-1:0] r_out_cnt;
  logic                         r_proto_err;

  logic              w_slot_free;
  logic [NUM_CH-1:0] w_elig;
  logic              w_hi_found, w_lo_found;
  logic [ID_W-1:0]   w_hi_idx, w_lo_idx;
  logic              w_gnt_vld;
  logic [ID_W-1:0]   w_gnt_idx;
  logic              w_rsp_hit, w_id_oob, w_zero_dec, w_err_set;

  assign w_slot_free = !r_slot_vld || l2_req_ready;

  // Two descending scans yield the lowest eligible index at/above rr_ptr and the lowest overall (wrap case).
  always_comb begin
    w_elig     = '0;
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_found = 1'b0;
    w_lo_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      w_elig[i] = req_valid[i] && (r_out_cnt[i] < CNT_W'(MAX_OUT));
      if (w_elig[i]) begin
        w_lo_found = 1'b1;
        w_lo_idx   = ID_W'(i);
        if (ID_W'(i) >= r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = ID_W'(i);
        end
      end
    end
    w_gnt_vld = rdy && w_slot_free && w_lo_found;
    w_gnt_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  assign w_rsp_hit = l2_rsp_valid && rdy;
  assign w_id_oob  = {1'b0, l2_rsp_id} >= (ID_W + 1)'(NUM_CH);

  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    w_zero_dec = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_ready[i] = w_gnt_vld && (w_gnt_idx == ID_W'(i));
      rsp_valid[i] = w_rsp_hit && (l2_rsp_id == ID_W'(i));
      if (rsp_valid[i] && (r_out_cnt[i] == '0)) w_zero_dec = 1'b1;
    end
    w_err_set = w_rsp_hit && (w_id_oob || w_zero_dec);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot_vld  <= 1'b0;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_wdata     <= '0;
      r_id        <= '0;
      r_rr_ptr    <= '0;
      r_out_cnt   <= '0;
      r_proto_err <= 1'b0;
    end else if (rdy) begin
      if (w_gnt_vld) begin
        r_slot_vld <= 1'b1;
        r_addr     <= req_addr[w_gnt_idx];
        r_we       <= req_we[w_gnt_idx];
        r_wdata    <= req_wdata[w_gnt_idx];
        r_id       <= w_gnt_idx;
        r_rr_ptr   <= (w_gnt_idx == ID_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
      end else if (l2_req_ready) begin
        r_slot_vld <= 1'b0;
      end
      // Grant and response on the same channel cancel; a decrement at zero saturates.
      for (int i = 0; i < NUM_CH; i++) begin
        if (req_ready[i] && !rsp_valid[i]) begin
          r_out_cnt[i] <= r_out_cnt[i] + 1'b1;
        end else if (!req_ready[i] && rsp_valid[i] && (r_out_cnt[i] != '0)) begin
          r_out_cnt[i] <= r_out_cnt[i] - 1'b1;
        end
      end
      if (w_err_set) r_proto_err <= 1'b1;
    end
  end

  assign l2_req_valid = r_slot_vld;
  assign l2_req_addr  = r_addr;
  assign l2_req_we    = r_we;
  assign l2_req_wdata = r_wdata;
  assign l2_req_id    = r_id;
  assign l2_rsp_ready = rdy;
  assign rsp_data     = l2_rsp_data;
  assign proto_err    = r_proto_err;

endmodule
